// File: rtl/ex_muldiv.sv
// Iterative MIPS multiply/divide unit for EX: owns HI/LO, decodes MULT/DIV/MFxx/MTxx.
// Fixed 33-cycle stall per mult/div (one shift-add or restoring step per BUSY cycle).
module ex_muldiv #(
  parameter logic [31:0] DIV0_LO = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instruction_EX,
  input  logic [31:0] Read_Data_1_EX,
  input  logic [31:0] Read_Data_2_EX,
  output logic        stall_req,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] mf_data,
  output logic        mf_valid
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  count;
  logic [31:0] acc_hi, acc_lo, opb, rs_raw, hi_q, lo_q;
  logic        op_div, neg_q, neg_r, div0;

  logic [5:0]  funct;
  logic        is_r, is_start, is_signed, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic        rs_neg, rt_neg;
  logic [31:0] abs_a, abs_b;

  assign funct     = instruction_EX[5:0];
  assign is_r      = (instruction_EX[31:26] == 6'd0);
  assign is_start  = is_r && (funct[5:2] == 4'b0110);
  assign is_signed = ~funct[0];
  assign is_mfhi   = is_r && (funct == 6'h10);
  assign is_mthi   = is_r && (funct == 6'h11);
  assign is_mflo   = is_r && (funct == 6'h12);
  assign is_mtlo   = is_r && (funct == 6'h13);

  assign rs_neg = is_signed && Read_Data_1_EX[31];
  assign rt_neg = is_signed && Read_Data_2_EX[31];
  assign abs_a  = rs_neg ? (32'd0 - Read_Data_1_EX) : Read_Data_1_EX;
  assign abs_b  = rt_neg ? (32'd0 - Read_Data_2_EX) : Read_Data_2_EX;

  logic unused_instr_bits;
  assign unused_instr_bits = ^instruction_EX[25:6];

  // One iteration: acc_hi is the running upper product / partial remainder,
  // acc_lo shifts out multiplier bits or dividend bits and shifts in quotient bits.
  logic [32:0] sum33, shifted, diff;
  logic [31:0] hi_nx, lo_nx, res_hi, res_lo;
  logic [63:0] prod;

  always_comb begin
    sum33   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : 33'd0);
    shifted = {acc_hi, acc_lo[31]};
    diff    = shifted - {1'b0, opb};
    if (op_div) begin
      if (!diff[32]) begin
        hi_nx = diff[31:0];
        lo_nx = {acc_lo[30:0], 1'b1};
      end else begin
        hi_nx = shifted[31:0];
        lo_nx = {acc_lo[30:0], 1'b0};
      end
    end else begin
      hi_nx = sum33[32:1];
      lo_nx = {sum33[0], acc_lo[31:1]};
    end

    prod = {hi_nx, lo_nx};
    if (neg_q) prod = 64'd0 - prod;

    if (op_div) begin
      if (div0) begin
        res_hi = rs_raw;
        res_lo = DIV0_LO;
      end else begin
        res_hi = neg_r ? (32'd0 - hi_nx) : hi_nx;
        res_lo = neg_q ? (32'd0 - lo_nx) : lo_nx;
      end
    end else begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      count  <= 5'd0;
      acc_hi <= 32'd0;
      acc_lo <= 32'd0;
      opb    <= 32'd0;
      rs_raw <= 32'd0;
      hi_q   <= 32'd0;
      lo_q   <= 32'd0;
      op_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (is_start) begin
            acc_hi <= 32'd0;
            acc_lo <= abs_a;
            opb    <= abs_b;
            rs_raw <= Read_Data_1_EX;
            op_div <= funct[1];
            neg_q  <= rs_neg ^ rt_neg;
            neg_r  <= rs_neg;
            div0   <= funct[1] && (Read_Data_2_EX == 32'd0);
            count  <= 5'd0;
            state  <= S_BUSY;
          end else if (is_mthi) begin
            hi_q <= Read_Data_1_EX;
          end else if (is_mtlo) begin
            lo_q <= Read_Data_1_EX;
          end
        end
        S_BUSY: begin
          acc_hi <= hi_nx;
          acc_lo <= lo_nx;
          count  <= count + 5'd1;
          if (count == 5'd31) begin
            hi_q  <= res_hi;
            lo_q  <= res_lo;
            state <= S_DONE;
          end
        end
        // The finished instruction is still in EX here; it must not restart.
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE);
  assign stall_req = !reset && (((state == S_IDLE) && is_start) || (state == S_BUSY));
  assign HI        = hi_q;
  assign LO        = lo_q;
  assign mf_valid  = is_mfhi || is_mflo;
  assign mf_data   = is_mfhi ? hi_q : (is_mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: directed and random ops against an arithmetic reference.
module tb_ex_muldiv;
  localparam logic [5:0]  F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0]  F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [31:0] DIV0 = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr, rs, rt;
  logic        stall_req, busy, mf_valid;
  logic [31:0] HI, LO, mf_data;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi, m_lo;

  ex_muldiv #(.DIV0_LO(DIV0)) dut (
    .clk(clk), .reset(reset), .instruction_EX(instr),
    .Read_Data_1_EX(rs), .Read_Data_2_EX(rt),
    .stall_req(stall_req), .busy(busy), .HI(HI), .LO(LO),
    .mf_data(mf_data), .mf_valid(mf_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_op(input logic [5:0] f);
    return {26'd0, f};
  endfunction

  // Reference: plain 64-bit arithmetic; SV / and % truncate toward zero as MIPS does.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    hi = 32'd0;
    lo = 32'd0;
    case (f)
      F_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      F_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      F_DIV, F_DIVU: begin
        if (b == 32'd0) begin
          hi = a;
          lo = DIV0;
        end else if (f == F_DIV) begin
          q = sa / sb; r = sa % sb;
          p = 64'(q); lo = p[31:0];
          p = 64'(r); hi = p[31:0];
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  // Present a start op in IDLE (cycle 0) and check the whole stall window through DONE (cycle 33).
  task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi;
    old_lo = m_lo;
    instr = r_op(f); rs = a; rt = b;
    #1;
    model(f, a, b, m_hi, m_lo);
    chk("stall_c0", 32'(stall_req), 32'd1);
    chk("busy_c0", 32'(busy), 32'd0);
    for (int k = 1; k <= 33; k++) begin
      next_cycle();
      rs = $urandom; rt = $urandom;
      #1;
      chk($sformatf("stall_c%0d", k), 32'(stall_req), 32'(k <= 32));
      chk($sformatf("busy_c%0d", k), 32'(busy), 32'd1);
      if (k == 32) begin
        chk("hi_hold_c32", HI, old_hi);
        chk("lo_hold_c32", LO, old_lo);
      end
      if (k == 33) begin
        chk($sformatf("HI f=%h a=%h b=%h", f, a, b), HI, m_hi);
        chk($sformatf("LO f=%h a=%h b=%h", f, a, b), LO, m_lo);
      end
    end
  endtask

  task automatic idle_nop;
    next_cycle();
    instr = 32'd0; rs = $urandom; rt = $urandom;
    #1;
    chk("nop_stall", 32'(stall_req), 32'd0);
    chk("nop_busy", 32'(busy), 32'd0);
    chk("nop_mf_valid", 32'(mf_valid), 32'd0);
  endtask

  task automatic read_hi_lo;
    next_cycle();
    instr = r_op(F_MFHI); #1;
    chk("mfhi_valid", 32'(mf_valid), 32'd1);
    chk("mfhi_data", mf_data, m_hi);
    chk("mfhi_stall", 32'(stall_req), 32'd0);
    next_cycle();
    instr = r_op(F_MFLO); #1;
    chk("mflo_data", mf_data, m_lo);
  endtask

  initial begin
    logic [5:0]  f;
    logic [31:0] a, b;
    reset = 1'b1;
    instr = r_op(F_MULT); rs = 32'd5; rt = 32'd6;
    m_hi = 32'd0; m_lo = 32'd0;
    #1;
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    chk("rst_mf_data", mf_data, 32'd0);
    next_cycle();
    next_cycle();
    reset = 1'b0;

    run_op(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle_nop();
    next_cycle();
    run_op(F_MULT, 32'hFFFF_FFFD, 32'd7);
    idle_nop();
    next_cycle();
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2);
    next_cycle();
    run_op(F_DIVU, 32'd7, 32'd0);
    read_hi_lo();

    next_cycle();
    instr = r_op(F_MTLO); rs = 32'h1234_5678; #1;
    chk("mtlo_stall", 32'(stall_req), 32'd0);
    m_lo = 32'h1234_5678;
    next_cycle();
    instr = r_op(F_MFLO); rs = $urandom; #1;
    chk("mflo_valid", 32'(mf_valid), 32'd1);
    chk("mflo_after_mtlo", mf_data, 32'h1234_5678);
    chk("mflo_stall", 32'(stall_req), 32'd0);
    next_cycle();
    a = $urandom;
    instr = r_op(F_MTHI); rs = a; #1;
    chk("mthi_stall", 32'(stall_req), 32'd0);
    m_hi = a;
    read_hi_lo();

    next_cycle();
    run_op(F_MULT, $urandom, $urandom);
    next_cycle();
    run_op(F_MULT, $urandom, $urandom);
    idle_nop();
    next_cycle();
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    next_cycle();
    run_op(F_DIV, 32'hFFFF_FF00, 32'd0);
    idle_nop();

    for (int i = 0; i < 10; i++) begin
      f = F_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(0, 31);
      next_cycle();
      run_op(f, a, b);
      read_hi_lo();
    end

    next_cycle();
    instr = r_op(F_DIV); rs = 32'hFFFF_FF9C; rt = 32'd7;
    for (int k = 0; k < 10; k++) next_cycle();
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1'b1; #1;
    chk("midrst_stall", 32'(stall_req), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_HI", HI, 32'd0);
    chk("midrst_LO", LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    next_cycle();
    reset = 1'b0;
    run_op(F_DIV, 32'hFFFF_FF9C, 32'd7);
    idle_nop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
